digit_serial_addsub: RTL and testbench

//  Parametrised digit-serial adder/subtractor; successor to the bit-serial Moore adder.

---
 rtl/serial_arith_pkg.sv | 13 +
 rtl/digit_serial_addsub_if.sv | 23 ++
 rtl/digit_adder.sv | 13 +
 rtl/digit_serial_addsub.sv | 82 ++++++++
 tb/tb_digit_serial_addsub.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared state encoding and sizing helper for the serial arithmetic blocks
package serial_arith_pkg;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;
  typedef enum logic [1:0] {IDLE = ST_IDLE, RUN = ST_RUN, DONE = ST_DONE} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/digit_serial_addsub_if.sv
// digit_serial_addsub_if: framing, operand digit and result bundle of the digit-serial adder
interface digit_serial_addsub_if #(parameter int DIGIT_W = 1);
  logic start;
  logic sub;
  logic in_valid;
  logic [DIGIT_W-1:0] a_dig;
  logic [DIGIT_W-1:0] b_dig;
  logic in_ready;
  logic [DIGIT_W-1:0] sum_dig;
  logic sum_valid;
  logic busy;
  logic done;
  logic cout;
  logic ovf;
  modport master (
    output start, sub, in_valid, a_dig, b_dig,
    input in_ready, sum_dig, sum_valid, busy, done, cout, ovf
  );
  modport slave (
    input start, sub, in_valid, a_dig, b_dig,
    output in_ready, sum_dig, sum_valid, busy, done, cout, ovf
  );
endinterface

// File: rtl/digit_adder.sv
// digit_adder: combinational DIGIT_W-bit adder exposing the carry into its top bit for overflow detection
module digit_adder #(parameter int DIGIT_W = 1) (
  input  logic [DIGIT_W-1:0] i_a,
  input  logic [DIGIT_W-1:0] i_b,
  input  logic               i_cin,
  output logic [DIGIT_W-1:0] o_sum,
  output logic               o_cout,
  output logic               o_c_msb_in
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT_W{1'b0}}, i_cin};
  // top-bit sum = a ^ b ^ cin, so the incoming carry falls out by xor
  assign o_c_msb_in = o_sum[DIGIT_W-1] ^ i_a[DIGIT_W-1] ^ i_b[DIGIT_W-1];
endmodule

// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: LSB-first digit-serial add/subtract with Moore outputs and end-of-word carry/overflow
module digit_serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int DIGIT_W = 1,
  parameter int NUM_DIGITS = 8
) (
  input logic clk,
  input logic rst,
  digit_serial_addsub_if.slave bus
);
  localparam int CW = clog2(NUM_DIGITS);
  localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);
  state_t r_state;
  logic r_carry;
  logic r_sub;
  logic [CW-1:0] r_count;
  logic [DIGIT_W-1:0] r_sum;
  logic r_sum_valid;
  logic r_done;
  logic r_cout;
  logic r_ovf;
  logic w_acc;
  logic [DIGIT_W-1:0] w_bb;
  logic [DIGIT_W-1:0] w_sum;
  logic w_cout;
  logic w_c_msb_in;
  assign w_acc = (r_state == RUN) && bus.in_valid;
  assign w_bb = r_sub ? ~bus.b_dig : bus.b_dig;
  digit_adder #(.DIGIT_W(DIGIT_W)) u_add (
    .i_a(bus.a_dig),
    .i_b(w_bb),
    .i_cin(r_carry),
    .o_sum(w_sum),
    .o_cout(w_cout),
    .o_c_msb_in(w_c_msb_in)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_carry <= 1'b0;
      r_sub <= 1'b0;
      r_count <= '0;
      r_sum <= '0;
      r_sum_valid <= 1'b0;
      r_done <= 1'b0;
      r_cout <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_sum_valid <= w_acc;
      r_done <= 1'b0;
      if (r_state == IDLE && bus.start) begin
        r_state <= RUN;
        r_carry <= bus.sub;
        r_sub <= bus.sub;
        r_count <= '0;
        r_cout <= 1'b0;
        r_ovf <= 1'b0;
      end
      if (r_state == DONE) r_state <= IDLE;
      if (w_acc) begin
        r_carry <= w_cout;
        r_sum <= w_sum;
        if (r_count == LAST) begin
          r_state <= DONE;
          r_done <= 1'b1;
          r_cout <= w_cout;
          r_ovf <= w_c_msb_in ^ w_cout;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  end
  assign bus.in_ready = r_state == RUN;
  assign bus.busy = r_state != IDLE;
  assign bus.sum_dig = r_sum;
  assign bus.sum_valid = r_sum_valid;
  assign bus.done = r_done;
  assign bus.cout = r_cout;
  assign bus.ovf = r_ovf;
endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb_digit_serial_addsub: drives a DW=1/ND=8 and a DW=4/ND=4 instance against an integer-arithmetic model
module tb_digit_serial_addsub;
  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic start;
  logic sub;
  logic in_valid;
  logic [3:0] a_dig;
  logic [3:0] b_dig;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  digit_serial_addsub_if #(.DIGIT_W(1)) ifc0 ();
  digit_serial_addsub_if #(.DIGIT_W(4)) ifc1 ();
  assign ifc0.start = start & ~sel;
  assign ifc0.sub = sub;
  assign ifc0.in_valid = in_valid & ~sel;
  assign ifc0.a_dig = a_dig[0];
  assign ifc0.b_dig = b_dig[0];
  assign ifc1.start = start & sel;
  assign ifc1.sub = sub;
  assign ifc1.in_valid = in_valid & sel;
  assign ifc1.a_dig = a_dig;
  assign ifc1.b_dig = b_dig;
  digit_serial_addsub #(.DIGIT_W(1), .NUM_DIGITS(8)) u_dut0 (.clk(clk), .rst(rst), .bus(ifc0));
  digit_serial_addsub #(.DIGIT_W(4), .NUM_DIGITS(4)) u_dut1 (.clk(clk), .rst(rst), .bus(ifc1));
  logic [3:0] o_sum;
  logic o_sv, o_ready, o_busy, o_done, o_cout, o_ovf;
  assign o_sum = sel ? ifc1.sum_dig : {3'b000, ifc0.sum_dig};
  assign o_sv = sel ? ifc1.sum_valid : ifc0.sum_valid;
  assign o_ready = sel ? ifc1.in_ready : ifc0.in_ready;
  assign o_busy = sel ? ifc1.busy : ifc0.busy;
  assign o_done = sel ? ifc1.done : ifc0.done;
  assign o_cout = sel ? ifc1.cout : ifc0.cout;
  assign o_ovf = sel ? ifc1.ovf : ifc0.ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // word-level reference: plain unsigned/signed arithmetic on the whole W-bit operands
  task automatic model(input bit s1, input logic sb, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] r, output logic c, output logic v);
    int w;
    longint m, half, ua, ub, sa, sbb, sr;
    w = s1 ? 16 : 8;
    m = longint'(1) << w;
    half = m / 2;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    sa = ua >= half ? ua - m : ua;
    sbb = ub >= half ? ub - m : ub;
    sr = sb ? sa - sbb : sa + sbb;
    v = (sr < -half) || (sr >= half);
    c = sb ? (ua >= ub) : ((ua + ub) >= m);
    r = 16'((sb ? ua - ub : ua + ub) & (m - 1));
  endtask

  task automatic run_word(input bit s1, input logic sb, input logic [15:0] a, input logic [15:0] b,
                          input int st1, input int st2, input bit noise);
    int nd, dw, d, pend, nst, cyc;
    logic v;
    logic [15:0] res, er;
    logic ec, eo;
    nd = s1 ? 4 : 8;
    dw = s1 ? 4 : 1;
    model(s1, sb, a, b, er, ec, eo);
    d = 0; pend = 0; nst = 0; res = '0;
    sel = s1;
    start = 1'b1;
    sub = sb;
    in_valid = noise;
    a_dig = 4'($urandom);
    b_dig = 4'($urandom);
    @(posedge clk); #1;
    cyc = 1;
    check("ready", o_ready, 1);
    check("sv_idle", o_sv, 0);
    check("clr", {o_cout, o_ovf}, 0);
    while (d < nd) begin
      if (pend > 0) begin
        v = 1'b0;
        pend--;
      end else v = !(noise && $urandom_range(0, 3) == 0);
      if (!v) nst++;
      in_valid = v;
      a_dig = v ? 4'((a >> (d * dw)) & ((1 << dw) - 1)) : 4'($urandom);
      b_dig = v ? 4'((b >> (d * dw)) & ((1 << dw) - 1)) : 4'($urandom);
      start = noise ? 1'($urandom) : 1'b0;
      if (noise) sub = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
      check("sum_valid", o_sv, v);
      if (v) begin
        res = res | (16'(o_sum) << (d * dw));
        d++;
        if (d == st1 || d == st2) pend = 2;
      end
      check("done", o_done, d == nd);
    end
    in_valid = 1'b0;
    start = 1'b0;
    check("latency", cyc, nd + 1 + nst);
    check("result", res, er);
    check("cout", o_cout, ec);
    check("ovf", o_ovf, eo);
    check("busy_done", {o_busy, o_ready}, 2'b10);
    start = noise;
    in_valid = noise;
    @(posedge clk); #1;
    check("idle", {o_busy, o_done, o_sv}, 0);
    check("hold", {o_cout, o_ovf}, {ec, eo});
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; start = 1'b0; sub = 1'b0; in_valid = 1'b0; a_dig = '0; b_dig = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst0", {o_busy, o_ready, o_sum, o_sv, o_done, o_cout, o_ovf}, 0);
    sel = 1'b1; #1;
    check("rst1", {o_busy, o_ready, o_sum, o_sv, o_done, o_cout, o_ovf}, 0);
    rst = 1'b0;
    run_word(0, 0, 16'h005A, 16'h003C, -1, -1, 0);
    run_word(0, 1, 16'h0010, 16'h0020, -1, -1, 0);
    run_word(0, 0, 16'h00FF, 16'h0001, 2, 5, 0);
    run_word(1, 0, 16'h7FFF, 16'h0001, -1, -1, 0);
    run_word(1, 1, 16'h8000, 16'h0001, -1, -1, 0);
    sel = 1'b0; start = 1'b1; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; a_dig = 4'h1; b_dig = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst", {o_busy, o_sum}, 5'b10001);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    check("mid_rst", {o_busy, o_ready, o_sum, o_sv, o_done, o_cout, o_ovf}, 0);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst", o_busy, 0);
    run_word(0, 0, 16'h0001, 16'h0001, -1, -1, 0);
    run_word(0, 0, 16'h005A, 16'h003C, -1, -1, 1);
    for (int k = 0; k < 12; k++)
      run_word(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
               $urandom_range(1, 3), $urandom_range(4, 6), 1'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
